// File: rtl/router_pkg.sv
// router_pkg: shared constants, flit type and destination-to-port mapping
// for the router output scheduling logic.
`default_nettype none

package router_pkg;

    localparam int N_OUT  = 3;
    localparam int DEST_W = 3;
    localparam int FLIT_W = 16;

    typedef logic [FLIT_W-1:0] flit_t;

    // Destinations 0-2 go to port 0, 3-5 to port 1, 6-7 to port 2.
    function automatic logic [1:0] dest_port(input logic [DEST_W-1:0] dest);
        logic [1:0] port;
        case (dest)
            3'd0, 3'd1, 3'd2: port = 2'd0;
            3'd3, 3'd4, 3'd5: port = 2'd1;
            default:          port = 2'd2;
        endcase
        return port;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first request at or after i_ptr
// with wrap-around, found by a priority search over a doubled request vector.
`default_nettype none

module rr_arbiter #(
    parameter int N  = 17,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic          o_any
);

    logic [2*N-1:0] w_dbl;
    int             w_sel;

    assign w_dbl = {i_req, i_req} >> i_ptr;
    assign o_any = |i_req;

    always_comb begin
        w_sel = -1;
        for (int i = 0; i < N; i++) begin
            if (w_sel < 0 && w_dbl[i]) begin
                w_sel = i + int'(i_ptr);
            end
        end
        // Hits in the upper copy map back to the low slot indices.
        if (w_sel >= N) begin
            w_sel = w_sel - N;
        end
        o_gnt = '0;
        for (int j = 0; j < N; j++) begin
            o_gnt[j] = (w_sel == j);
        end
    end

endmodule

`default_nettype wire

// File: rtl/router_out_arbiter.sv
// router_out_arbiter: per-output round-robin scheduler feeding three registered
// valid/ready output stages from N_IN input slots routed by flit destination.
`default_nettype none

module router_out_arbiter
    import router_pkg::*;
#(
    parameter int N_IN = 17,
    parameter int DW   = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_arb_en,
    input  logic [N_IN-1:0] i_req_valid,
    input  logic [DW-1:0] i_req_data [N_IN],
    output logic [N_IN-1:0] o_req_grant,
    output logic [DW-1:0] o_out_data [N_OUT],
    output logic [N_OUT-1:0] o_out_valid,
    input  logic [N_OUT-1:0] i_out_ready,
    output logic [7:0]    o_grant_cnt [N_OUT]
);

    localparam int PW = $clog2(N_IN);

    logic [N_IN-1:0]  w_req     [N_OUT];
    logic [N_IN-1:0]  w_arb_gnt [N_OUT];
    logic [N_IN-1:0]  w_gnt     [N_OUT];
    logic [DW-1:0]    w_mux     [N_OUT];
    logic [PW-1:0]    w_nptr    [N_OUT];
    logic [N_OUT-1:0] w_any;
    logic [N_OUT-1:0] w_fire;

    logic [PW-1:0]    r_ptr     [N_OUT];
    logic [DW-1:0]    r_data    [N_OUT];
    logic [N_OUT-1:0] r_valid;
    logic [7:0]       r_cnt     [N_OUT];

    always_comb begin
        for (int k = 0; k < N_OUT; k++) begin
            for (int i = 0; i < N_IN; i++) begin
                w_req[k][i] = i_req_valid[i] &&
                    (dest_port(i_req_data[i][DW-1 -: DEST_W]) == 2'(k));
            end
        end
    end

    generate
        for (genvar k = 0; k < N_OUT; k++) begin : g_out
            rr_arbiter #(
                .N  (N_IN),
                .PW (PW)
            ) u_rr (
                .i_req (w_req[k]),
                .i_ptr (r_ptr[k]),
                .o_gnt (w_arb_gnt[k]),
                .o_any (w_any[k])
            );

            // Refill is allowed in the same cycle the current flit drains.
            assign w_fire[k] = rst_n & i_arb_en & w_any[k] &
                               (~r_valid[k] | i_out_ready[k]);
            assign w_gnt[k]  = w_fire[k] ? w_arb_gnt[k] : '0;
        end
    endgenerate

    always_comb begin
        for (int k = 0; k < N_OUT; k++) begin
            w_mux[k]  = '0;
            w_nptr[k] = r_ptr[k];
            for (int i = 0; i < N_IN; i++) begin
                if (w_arb_gnt[k][i]) begin
                    w_mux[k]  = i_req_data[i];
                    w_nptr[k] = (i == N_IN - 1) ? '0 : PW'(i + 1);
                end
            end
        end
    end

    always_comb begin
        o_req_grant = '0;
        for (int k = 0; k < N_OUT; k++) begin
            o_req_grant = o_req_grant | w_gnt[k];
            o_out_data[k]  = r_data[k];
            o_grant_cnt[k] = r_cnt[k];
        end
    end

    assign o_out_valid = r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int k = 0; k < N_OUT; k++) begin
                r_ptr[k]  <= '0;
                r_data[k] <= '0;
                r_cnt[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < N_OUT; k++) begin
                if (w_fire[k]) begin
                    r_data[k]  <= w_mux[k];
                    r_valid[k] <= 1'b1;
                    r_ptr[k]   <= w_nptr[k];
                    if (r_cnt[k] != 8'hFF) begin
                        r_cnt[k] <= r_cnt[k] + 8'd1;
                    end
                end else if (i_out_ready[k]) begin
                    r_valid[k] <= 1'b0;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_router_out_arbiter.sv
// tb_router_out_arbiter: randomized stimulus against a slot-level scheduling
// model of the three output ports.
`default_nettype none

module tb_router_out_arbiter;

    localparam int N  = 17;
    localparam int DW = 16;

    logic          clk;
    logic          rst_n;
    logic          arb_en;
    logic [N-1:0]  req_valid;
    logic [DW-1:0] req_data [N];
    logic [N-1:0]  req_grant;
    logic [DW-1:0] out_data [3];
    logic [2:0]    out_valid;
    logic [2:0]    out_ready;
    logic [7:0]    grant_cnt [3];

    router_out_arbiter #(.N_IN(N), .DW(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_arb_en    (arb_en),
        .i_req_valid (req_valid),
        .i_req_data  (req_data),
        .o_req_grant (req_grant),
        .o_out_data  (out_data),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_grant_cnt (grant_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Slot contents and the expected state of each output port.
    logic          sv [N];
    logic [DW-1:0] sd [N];
    int            mptr [3];
    logic          mv [3];
    logic [DW-1:0] md [3];
    int            mc [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 3; k++) begin
            mptr[k] = 0;
            mv[k]   = 1'b0;
            md[k]   = '0;
            mc[k]   = 0;
        end
    endtask

    task automatic drive_slots();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = sv[i];
            req_data[i]  = sd[i];
        end
    endtask

    task automatic check_outputs();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("out_valid%0d", k), 32'(out_valid[k]), 32'(mv[k]));
            chk($sformatf("out_data%0d", k), 32'(out_data[k]), 32'(md[k]));
            chk($sformatf("grant_cnt%0d", k), 32'(grant_cnt[k]), mc[k]);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    // mode 0: random traffic; mode 1: every slot targets destination 3.
    task automatic run_cycle(input int mode);
        logic [N-1:0] eg;
        int win, s;
        check_outputs();
        for (int i = 0; i < N; i++) begin
            if (!sv[i]) begin
                if (mode == 1) begin
                    sv[i] = 1'b1;
                    sd[i] = {3'd3, 13'($urandom)};
                end else if ($urandom_range(1) == 1) begin
                    sv[i] = 1'b1;
                    sd[i] = 16'($urandom);
                end
            end
        end
        if (mode == 1) begin
            arb_en    = 1'b1;
            out_ready = 3'($urandom) | 3'b010;
        end else begin
            arb_en = ($urandom_range(9) != 0);
            for (int k = 0; k < 3; k++) out_ready[k] = ($urandom_range(3) != 0);
        end
        drive_slots();
        #1;
        eg = '0;
        for (int k = 0; k < 3; k++) begin
            win = -1;
            if (arb_en && (!mv[k] || out_ready[k])) begin
                for (int i = 0; i < N; i++) begin
                    s = (mptr[k] + i) % N;
                    if (win < 0 && sv[s] && (int'(sd[s][15:13]) / 3) == k) win = s;
                end
            end
            if (win >= 0) begin
                eg[win] = 1'b1;
                md[k]   = sd[win];
                mv[k]   = 1'b1;
                mptr[k] = (win + 1) % N;
                if (mc[k] < 255) mc[k]++;
            end else if (out_ready[k]) begin
                mv[k] = 1'b0;
            end
        end
        chk("req_grant", 32'(req_grant), 32'(eg));
        for (int i = 0; i < N; i++) if (eg[i]) sv[i] = 1'b0;
        @(negedge clk);
    endtask

    // Asynchronous reset between edges; slots are not popped while held.
    task automatic mid_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_cnt0", 32'(grant_cnt[0]), 32'd0);
        chk("rst_data0", 32'(out_data[0]), 32'd0);
        chk("rst_grant", 32'(req_grant), 32'd0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        arb_en    = 1'b1;
        out_ready = 3'b111;
        for (int i = 0; i < N; i++) begin
            sv[i] = 1'b1;
            sd[i] = {3'd0, 13'($urandom)};
        end
        drive_slots();
        model_clear();
        @(negedge clk);
        @(negedge clk);
        chk("reset_grant", 32'(req_grant), 32'd0);
        chk("reset_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;

        for (int c = 0; c < 4; c++) run_cycle(0);

        // Rotation through all slots on one output, including the wrap.
        for (int i = 0; i < N; i++) begin
            sv[i] = 1'b1;
            sd[i] = {3'd3, 13'($urandom)};
        end
        for (int c = 0; c < 40; c++) run_cycle(1);

        for (int c = 0; c < 1000; c++) run_cycle(0);
        chk("cnt0_sat", 32'(grant_cnt[0]), 32'd255);
        mid_reset();

        for (int c = 0; c < 200; c++) run_cycle(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
